// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types for the SDRAM request arbiter and its queues.
package sdram_pkg;
   typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS} dram_cmd_t;
   typedef enum logic {IDLE, GAP} arb_state_t;
   typedef enum logic {GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: power-of-two request queue; push is accepted while not full,
// pop is a strobe that is ignored when empty.
module sdram_req_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push_valid,
   input  logic [Width-1:0] i_push_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);
   localparam int PtrW = $clog2(Depth);
   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [PtrW:0]    r_count;
   logic             w_push;
   logic             w_pop;
   assign o_full  = r_count == (PtrW+1)'(Depth);
   assign o_empty = r_count == '0;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push_valid & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
         r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
      end
   always_ff @(posedge i_clk)
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
endmodule

// File: rtl/sdram_req_arb.sv
// sdram_req_arb: queues user writes/reads and issues them to the SDRAM controller with a
// minimum issue gap and in-order read return. Define SDRAM_ARB_RD_PRIO_EN for strict read priority.
module sdram_req_arb
   import sdram_pkg::*;
#(
   parameter int AddrWidth = 13,
   parameter int DataWidth = 16,
   parameter int FifoDepth = 4,
   parameter int IssueGap  = 8,
   parameter int RdLatency = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_wr_valid,
   output logic                 o_wr_ready,
   input  logic [AddrWidth-1:0] i_wr_addr,
   input  logic [DataWidth-1:0] i_wr_data,
   input  logic                 i_rd_valid,
   output logic                 o_rd_ready,
   input  logic [AddrWidth-1:0] i_rd_addr,
   output logic                 o_rd_valid,
   output logic [DataWidth-1:0] o_rd_data,
   output logic                 o_ctrl_wr_req,
   output logic [AddrWidth-1:0] o_ctrl_wr_addr,
   output logic [DataWidth-1:0] o_ctrl_wr_data,
   output logic                 o_ctrl_rd_req,
   output logic [AddrWidth-1:0] o_ctrl_rd_addr,
   input  logic [DataWidth-1:0] i_ctrl_rd_data
);
   localparam int GapW = $clog2(IssueGap + 1);
   logic [AddrWidth+DataWidth-1:0] w_wr_head;
   logic [AddrWidth-1:0]           w_rd_head;
   logic                           w_wr_empty, w_wr_full, w_rd_empty, w_rd_full;
   logic                           w_issue, w_sel_rd;
   arb_state_t                     w_state;
   grant_t                         r_last;
   logic [GapW-1:0]                r_gap;
   logic [RdLatency-1:0]           r_trk;
   sdram_req_fifo #(.Width(AddrWidth + DataWidth), .Depth(FifoDepth)) u_wr_fifo (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push_valid (i_wr_valid),
      .i_push_data  ({i_wr_addr, i_wr_data}),
      .i_pop        (w_issue & ~w_sel_rd),
      .o_head       (w_wr_head),
      .o_empty      (w_wr_empty),
      .o_full       (w_wr_full)
   );
   sdram_req_fifo #(.Width(AddrWidth), .Depth(FifoDepth)) u_rd_fifo (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push_valid (i_rd_valid),
      .i_push_data  (i_rd_addr),
      .i_pop        (w_issue & w_sel_rd),
      .o_head       (w_rd_head),
      .o_empty      (w_rd_empty),
      .o_full       (w_rd_full)
   );
   // ready is forced low while reset is held so every output reads 0 in reset
   assign o_wr_ready = i_rst_n & ~w_wr_full;
   assign o_rd_ready = i_rst_n & ~w_rd_full;
   assign w_state    = r_gap == '0 ? IDLE : GAP;
   assign w_issue    = (w_state == IDLE) && !(w_wr_empty && w_rd_empty);
`ifdef SDRAM_ARB_RD_PRIO_EN
   assign w_sel_rd   = ~w_rd_empty;
`else
   assign w_sel_rd   = ~w_rd_empty & (w_wr_empty | (r_last == GNT_WR));
`endif
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_gap          <= '0;
         r_last         <= GNT_RD;
         r_trk          <= '0;
         o_ctrl_wr_req  <= 1'b0;
         o_ctrl_rd_req  <= 1'b0;
         o_ctrl_wr_addr <= '0;
         o_ctrl_wr_data <= '0;
         o_ctrl_rd_addr <= '0;
         o_rd_valid     <= 1'b0;
         o_rd_data      <= '0;
      end else begin
         o_ctrl_wr_req <= w_issue & ~w_sel_rd;
         o_ctrl_rd_req <= w_issue & w_sel_rd;
         if (w_issue) begin
            r_gap  <= GapW'(IssueGap - 1);
            r_last <= w_sel_rd ? GNT_RD : GNT_WR;
         end else if (w_state == GAP) r_gap <= r_gap - GapW'(1);
         if (w_issue && !w_sel_rd) {o_ctrl_wr_addr, o_ctrl_wr_data} <= w_wr_head;
         if (w_issue && w_sel_rd) o_ctrl_rd_addr <= w_rd_head;
         // issued reads walk the tracker; the bit leaving it marks the data-valid cycle
         r_trk      <= RdLatency'({r_trk, o_ctrl_rd_req});
         o_rd_valid <= r_trk[RdLatency-1];
         if (r_trk[RdLatency-1]) o_rd_data <= i_ctrl_rd_data;
      end
endmodule

// File: tb/tb_sdram_req_arb.sv
// tb_sdram_req_arb: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of the arbiter.
module tb_sdram_req_arb;
   localparam int AW = 13, DW = 16, FD = 4, IG = 8, RL = 10;
   logic          clk = 0, rst_n = 0;
   logic          i_wr_valid = 0, i_rd_valid = 0;
   logic [AW-1:0] i_wr_addr = '0, i_rd_addr = '0;
   logic [DW-1:0] i_wr_data = '0, i_ctrl_rd_data = '0;
   logic          o_wr_ready, o_rd_ready, o_rd_valid, o_ctrl_wr_req, o_ctrl_rd_req;
   logic [DW-1:0] o_rd_data, o_ctrl_wr_data;
   logic [AW-1:0] o_ctrl_wr_addr, o_ctrl_rd_addr;
   int            checks = 0, errors = 0, cyc = 0;

   sdram_req_arb #(.AddrWidth(AW), .DataWidth(DW), .FifoDepth(FD), .IssueGap(IG), .RdLatency(RL)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
      .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
      .o_ctrl_wr_req(o_ctrl_wr_req), .o_ctrl_wr_addr(o_ctrl_wr_addr), .o_ctrl_wr_data(o_ctrl_wr_data),
      .o_ctrl_rd_req(o_ctrl_rd_req), .o_ctrl_rd_addr(o_ctrl_rd_addr), .i_ctrl_rd_data(i_ctrl_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // behavioural model: queues, next-allowed issue cycle, read-return due list
   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
   wr_t           wq[$];
   logic [AW-1:0] rq[$];
   int            due[$];
   int            next_ok = 0, n, nw, nr;
   bit            last_rd = 1, go, rd;
   wr_t           w;
   logic          e_wr_req = 0, e_rd_req = 0, e_rd_valid = 0;
   logic [AW-1:0] e_wr_addr = '0, e_rd_addr = '0;
   logic [DW-1:0] e_wr_data = '0, e_rd_data = '0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         wq.delete(); rq.delete(); due.delete();
         next_ok = 0; last_rd = 1;
         e_wr_req = 0; e_rd_req = 0; e_rd_valid = 0;
         e_wr_addr = '0; e_wr_data = '0; e_rd_addr = '0; e_rd_data = '0;
      end else begin
         n = cyc + 1;
         nw = wq.size(); nr = rq.size();
`ifdef SDRAM_ARB_RD_PRIO_EN
         rd = nr > 0;
`else
         rd = nr > 0 && (nw == 0 || !last_rd);
`endif
         go = n >= next_ok && nw + nr > 0;
         e_wr_req = go && !rd;
         e_rd_req = go && rd;
         if (go) begin next_ok = n + IG; last_rd = rd; end
         if (e_wr_req) begin w = wq.pop_front(); e_wr_addr = w.a; e_wr_data = w.d; end
         if (e_rd_req) begin e_rd_addr = rq.pop_front(); due.push_back(n + RL + 1); end
         e_rd_valid = due.size() > 0 && due[0] == n;
         if (e_rd_valid) begin e_rd_data = i_ctrl_rd_data; void'(due.pop_front()); end
         if (i_wr_valid && nw < FD) wq.push_back('{i_wr_addr, i_wr_data});
         if (i_rd_valid && nr < FD) rq.push_back(i_rd_addr);
      end
   end

   // per-cycle compare plus issue/return logs for the directed scenarios
   int            l_cyc[$], v_cyc[$];
   bit            l_rd[$];
   logic [AW-1:0] l_addr[$];
   logic [DW-1:0] l_data[$], v_data[$];

   initial forever begin
      @(negedge clk);
      chk("wr_ready", o_wr_ready, rst_n && wq.size() < FD);
      chk("rd_ready", o_rd_ready, rst_n && rq.size() < FD);
      chk("ctrl_wr_req", o_ctrl_wr_req, e_wr_req);
      chk("ctrl_rd_req", o_ctrl_rd_req, e_rd_req);
      chk("ctrl_wr_addr", o_ctrl_wr_addr, e_wr_addr);
      chk("ctrl_wr_data", o_ctrl_wr_data, e_wr_data);
      chk("ctrl_rd_addr", o_ctrl_rd_addr, e_rd_addr);
      chk("rd_valid", o_rd_valid, e_rd_valid);
      chk("rd_data", o_rd_data, e_rd_data);
      chk("req_exclusive", o_ctrl_wr_req & o_ctrl_rd_req, 0);
      if (o_ctrl_wr_req) begin
         l_cyc.push_back(cyc); l_rd.push_back(0); l_addr.push_back(o_ctrl_wr_addr); l_data.push_back(o_ctrl_wr_data);
      end
      if (o_ctrl_rd_req) begin
         l_cyc.push_back(cyc); l_rd.push_back(1); l_addr.push_back(o_ctrl_rd_addr); l_data.push_back('0);
      end
      if (o_rd_valid) begin v_cyc.push_back(cyc); v_data.push_back(o_rd_data); end
   end

   task automatic tick();
      @(posedge clk);
      #1 i_ctrl_rd_data = DW'($urandom);
   endtask

   task automatic clear_logs();
      l_cyc.delete(); l_rd.delete(); l_addr.delete(); l_data.delete(); v_cyc.delete(); v_data.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 0;
      i_wr_valid = 0; i_rd_valid = 0;
      repeat (2) tick();
      rst_n = 1;
      clear_logs();
   endtask

   task automatic push(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc, output int st);
      logic r;
      int   k;
      st = 0;
      if (is_rd) begin i_rd_valid = 1; i_rd_addr = a; end
      else begin i_wr_valid = 1; i_wr_addr = a; i_wr_data = d; end
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         r = is_rd ? o_rd_ready : o_wr_ready;
         tick();
         if (r) break;
         st++;
      end
      chk("push_timeout", k < 100, 1);
      acc = cyc;
      i_wr_valid = 0; i_rd_valid = 0;
   endtask

   task automatic wait_issue(input int cnt);
      for (int k = 0; k < 60 && l_cyc.size() < cnt; k++) tick();
      chk("issue_timeout", l_cyc.size() >= cnt, 1);
   endtask

   int            ka, kb, st, p, thr;
   int            acc[5];
   bit            eo_rd[4];
   logic [AW-1:0] eo_a[4];

   initial begin
      do_reset();
      // single write, then a second to measure the gap
      push(0, 13'h0123, 16'hBEEF, ka, st);
      push(0, 13'h0124, 16'h1111, kb, st);
      repeat (20) tick();
      chk("A_count", l_cyc.size(), 2);
      if (l_cyc.size() == 2) begin
         chk("A_type", l_rd[0], 0);
         chk("A_addr", l_addr[0], 13'h0123);
         chk("A_data", l_data[0], 16'hBEEF);
         chk("A_latency", l_cyc[0], ka + 1);
         chk("A_gap", l_cyc[1] - l_cyc[0], 8);
      end
      // two writes and two reads queued together
      do_reset();
`ifdef SDRAM_ARB_RD_PRIO_EN
      eo_rd = '{1, 1, 0, 0}; eo_a = '{13'h20, 13'h21, 13'h10, 13'h11};
`else
      eo_rd = '{0, 1, 0, 1}; eo_a = '{13'h10, 13'h20, 13'h11, 13'h21};
`endif
      i_wr_valid = 1; i_rd_valid = 1; i_wr_addr = 13'h10; i_wr_data = 16'h0A0A; i_rd_addr = 13'h20;
      tick();
      i_wr_addr = 13'h11; i_wr_data = 16'h0B0B; i_rd_addr = 13'h21;
      tick();
      i_wr_valid = 0; i_rd_valid = 0;
      repeat (40) tick();
      chk("B_count", l_cyc.size(), 4);
      for (int i = 0; i < 4 && i < l_cyc.size(); i++) begin
         chk($sformatf("B_type%0d", i), l_rd[i], eo_rd[i]);
         chk($sformatf("B_addr%0d", i), l_addr[i], eo_a[i]);
         if (i > 0) chk($sformatf("B_gap%0d", i), l_cyc[i] - l_cyc[i-1], 8);
      end
      // read return timing and data
      do_reset();
      push(1, 13'h0456, '0, ka, st);
      wait_issue(1);
      p = l_cyc.size() > 0 ? l_cyc[0] : cyc;
      chk("C_latency", p, ka + 1);
      chk("C_addr", l_addr.size() > 0 ? l_addr[0] : '0, 13'h0456);
      for (int k = 0; k < 40 && cyc < p + RL; k++) tick();
      i_ctrl_rd_data = 16'hA5A5;
      repeat (15) tick();
      chk("C_valid_count", v_cyc.size(), 1);
      if (v_cyc.size() == 1) begin
         chk("C_valid_cycle", v_cyc[0] - p, 11);
         chk("C_data", v_data[0], 16'hA5A5);
      end
      // backpressure: five writes queued behind an in-gap issue
      do_reset();
      push(0, 13'h30, 16'h3000, ka, st);
      for (int i = 0; i < 5; i++) push(0, AW'(13'h31 + i), DW'(16'h3100 + i), acc[i], st);
      chk("D_acc4", acc[3] - acc[0], 3);
      chk("D_stalls", st, 5);
      chk("D_first_issue", l_cyc.size() > 0 ? l_cyc[0] : 0, ka + 1);
      chk("D_acc5", acc[4], l_cyc.size() > 1 ? l_cyc[1] + 1 : 0);
      // reset with a read in flight and one still queued
      do_reset();
      push(1, 13'h40, '0, ka, st);
      push(1, 13'h41, '0, kb, st);
      wait_issue(1);
      repeat (3) tick();
      rst_n = 0;
      #1 chk("E_rst_outs", {o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data, o_ctrl_wr_req, o_ctrl_wr_addr,
                            o_ctrl_wr_data, o_ctrl_rd_req, o_ctrl_rd_addr}, 0);
      repeat (2) tick();
      rst_n = 1;
      clear_logs();
      repeat (20) tick();
      chk("E_no_valid", v_cyc.size(), 0);
      chk("E_no_issue", l_cyc.size(), 0);
      // randomized traffic in three load phases with a reset mid-run
      for (int i = 0; i < 3000; i++) begin
         thr = i < 1000 ? 16 : (i < 2000 ? 4 : 2);
         i_wr_valid = ($urandom % thr) == 0;
         i_rd_valid = ($urandom % thr) == 0;
         i_wr_addr = AW'($urandom); i_wr_data = DW'($urandom); i_rd_addr = AW'($urandom);
         if (i == 1500) begin
            rst_n = 0;
            tick();
            rst_n = 1;
         end
         tick();
      end
      i_wr_valid = 0; i_rd_valid = 0;
      repeat (40) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end
endmodule
